// File: rtl/speed_pwm_ramp.sv
// speed_pwm_ramp
// Turns the 2-bit speed code into a target PWM duty and walks the applied
// duty toward it one count per step. Duty only changes when the PWM counter
// wraps, so every PWM period is generated with a single duty value.
module speed_pwm_ramp #(
  parameter int unsigned PRESC_DIV = 195,
  parameter int unsigned RAMP_DIV  = 4,
  parameter int unsigned DUTY_SLOW = 64,
  parameter int unsigned DUTY_MED  = 160,
  parameter int unsigned DUTY_FAST = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] speed_select,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic       at_target
);

  // A divide-by-1 still needs a one-bit counter that simply sits at zero.
  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);

  localparam logic [7:0] SLOW_LEVEL = 8'(DUTY_SLOW);
  localparam logic [7:0] MED_LEVEL  = 8'(DUTY_MED);
  localparam logic [7:0] FAST_LEVEL = 8'(DUTY_FAST);

  logic [1:0]         target_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         pwm_cnt;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic [7:0]         duty_cur;
  logic [7:0]         target_duty;
  logic               tick;
  logic               period_end;
  logic               step;

  assign tick       = (presc_cnt == PRESC_LAST);
  assign period_end = tick && (pwm_cnt == 8'd255);
  assign step       = period_end && (ramp_cnt == RAMP_LAST);

  // Register the speed code once so the ramp always sees a stable target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q <= 2'b00;
    end else begin
      target_q <= speed_select;
    end
  end

  // Prescaler producing one PWM tick every PRESC_DIV clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // 8-bit PWM counter; the natural 255->0 wrap marks the period boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= 8'd0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Count PWM periods between duty steps; a new target does not restart it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_cnt <= '0;
    end else if (period_end) begin
      if (ramp_cnt == RAMP_LAST) begin
        ramp_cnt <= '0;
      end else begin
        ramp_cnt <= ramp_cnt + RAMP_W'(1);
      end
    end
  end

  // Decode the registered speed code into its duty level.
  always_comb begin
    target_duty = 8'd0;
    case (target_q)
      2'b01:   target_duty = SLOW_LEVEL;
      2'b10:   target_duty = MED_LEVEL;
      2'b11:   target_duty = FAST_LEVEL;
      default: target_duty = 8'd0;
    endcase
  end

  // Move the applied duty one count toward the target on each step; the
  // strict compares mean it can never pass 0 or 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_cur <= 8'd0;
    end else if (step) begin
      if (duty_cur < target_duty) begin
        duty_cur <= duty_cur + 8'd1;
      end else if (duty_cur > target_duty) begin
        duty_cur <= duty_cur - 8'd1;
      end
    end
  end

  // Registered comparator drives the pin, one clock behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < duty_cur);
    end
  end

  assign duty      = duty_cur;
  assign at_target = (duty_cur == target_duty);

endmodule

// File: tb/tb_speed_pwm_ramp.sv
// tb_speed_pwm_ramp
// Directed bench for speed_pwm_ramp with PRESC_DIV=1 and RAMP_DIV=1, so one
// PWM period is 256 clocks and duty moves one count per period.
// dut_a follows the whole sequence; dut_b shares clock and speed code but has
// its own reset so it can be hit asynchronously mid-ramp while dut_a goes on.
module tb_speed_pwm_ramp;

  logic       clk;
  logic       reset_n;
  logic       reset_n_b;
  logic [1:0] speed_select;
  logic       pwm_out_a;
  logic [7:0] duty_a;
  logic       at_target_a;
  logic       pwm_out_b;
  logic [7:0] duty_b;
  logic       at_target_b;

  int total_count = 0;
  int bad_count   = 0;
  int highs;
  int h1;
  int h2;
  int h3;

  speed_pwm_ramp #(.PRESC_DIV(1), .RAMP_DIV(1)) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .speed_select (speed_select),
    .pwm_out      (pwm_out_a),
    .duty         (duty_a),
    .at_target    (at_target_a)
  );

  speed_pwm_ramp #(.PRESC_DIV(1), .RAMP_DIV(1)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n_b),
    .speed_select (speed_select),
    .pwm_out      (pwm_out_b),
    .duty         (duty_b),
    .at_target    (at_target_b)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the shared speed code.
  task automatic applyStimulus(input logic [1:0] sel);
    speed_select = sel;
  endtask

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    assert (observed === expected) else begin
      bad_count++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 unit after the last one.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count how many of the next n post-edge samples of dut_a's pin are high.
  task automatic countHighs(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pwm_out_a === 1'b1) hi++;
    end
  endtask

  // Directed sequence; comments give the expected pwm_cnt phase of dut_a.
  initial begin
    reset_n   = 1'b0;
    reset_n_b = 1'b0;
    applyStimulus(2'b00);
    waitCycles(3);
    checkOutput("reset_pwm", 32'(pwm_out_a), 32'd0);
    checkOutput("reset_duty", 32'(duty_a), 32'd0);
    checkOutput("reset_at_target", 32'(at_target_a), 32'd1);
    reset_n   = 1'b1;
    reset_n_b = 1'b1;

    // OFF for three full periods: pin never goes high. Phase ends at 0.
    countHighs(768, highs);
    checkOutput("off_3_periods_highs", 32'(highs), 32'd0);
    checkOutput("off_duty", 32'(duty_a), 32'd0);

    // 00 -> 01: at_target drops only after the next edge registers the code.
    applyStimulus(2'b01);
    checkOutput("at_target_before_edge", 32'(at_target_a), 32'd1);
    waitCycles(1);
    checkOutput("at_target_after_edge", 32'(at_target_a), 32'd0);
    waitCycles(254);
    checkOutput("duty_before_first_step", 32'(duty_a), 32'd0);
    waitCycles(1);
    checkOutput("duty_first_step", 32'(duty_a), 32'd1);
    waitCycles(29 * 256);
    checkOutput("duty_reached_30", 32'(duty_a), 32'd30);

    // Reversal at 30: next step must give 29, then down to 0.
    applyStimulus(2'b00);
    waitCycles(256);
    checkOutput("reversal_step", 32'(duty_a), 32'd29);
    waitCycles(28 * 256);
    checkOutput("reversal_duty_1", 32'(duty_a), 32'd1);
    waitCycles(256);
    checkOutput("reversal_duty_0", 32'(duty_a), 32'd0);
    checkOutput("reversal_at_target", 32'(at_target_a), 32'd1);
    countHighs(256, highs);
    checkOutput("duty0_highs", 32'(highs), 32'd0);
    checkOutput("duty0_hold", 32'(duty_a), 32'd0);

    // Code change on the same edge as a step: the step uses the old target.
    waitCycles(255);
    applyStimulus(2'b01);
    waitCycles(1);
    checkOutput("simul_step_old_target", 32'(duty_a), 32'd0);
    checkOutput("simul_at_target", 32'(at_target_a), 32'd0);
    waitCycles(256);
    checkOutput("simul_next_step", 32'(duty_a), 32'd1);

    // Finish the ramp to SLOW.
    waitCycles(62 * 256);
    checkOutput("slow_duty_63", 32'(duty_a), 32'd63);
    checkOutput("slow_at_target_low", 32'(at_target_a), 32'd0);
    waitCycles(256);
    checkOutput("slow_duty_64", 32'(duty_a), 32'd64);
    checkOutput("slow_at_target_high", 32'(at_target_a), 32'd1);
    countHighs(256, highs);
    checkOutput("slow_highs_per_period", 32'(highs), 32'd64);

    // 01 -> 11 at pwm_cnt=100: this period keeps duty 64 throughout.
    countHighs(100, h1);
    applyStimulus(2'b11);
    countHighs(155, h2);
    checkOutput("glitch_duty_held", 32'(duty_a), 32'd64);
    checkOutput("glitch_at_target", 32'(at_target_a), 32'd0);
    countHighs(1, h3);
    checkOutput("glitch_period_highs", 32'(h1 + h2 + h3), 32'd64);
    checkOutput("glitch_step_at_end", 32'(duty_a), 32'd65);

    // Ramp to 100, then hit dut_b with an async reset between clock edges.
    waitCycles(35 * 256);
    checkOutput("ramp_duty_100", 32'(duty_a), 32'd100);
    checkOutput("ramp_b_duty_100", 32'(duty_b), 32'd100);
    waitCycles(10);
    checkOutput("pwm_high_mid_period", 32'(pwm_out_a), 32'd1);
    checkOutput("pwm_b_high_mid_period", 32'(pwm_out_b), 32'd1);
    #2;
    reset_n_b = 1'b0;
    #1;
    checkOutput("async_reset_pwm", 32'(pwm_out_b), 32'd0);
    checkOutput("async_reset_duty", 32'(duty_b), 32'd0);
    checkOutput("async_reset_at_target", 32'(at_target_b), 32'd1);
    checkOutput("async_reset_other_dut", 32'(duty_a), 32'd100);
    waitCycles(2);
    checkOutput("reset_held_duty", 32'(duty_b), 32'd0);
    reset_n_b = 1'b1;
    waitCycles(255);
    checkOutput("restart_before_step", 32'(duty_b), 32'd0);
    waitCycles(1);
    checkOutput("restart_first_step", 32'(duty_b), 32'd1);

    // Realign dut_a to phase 0: two boundaries crossed since 100 -> 102.
    waitCycles(244);
    checkOutput("fast_duty_102", 32'(duty_a), 32'd102);
    waitCycles(152 * 256);
    checkOutput("fast_duty_254", 32'(duty_a), 32'd254);
    waitCycles(256);
    checkOutput("fast_duty_255", 32'(duty_a), 32'd255);
    checkOutput("fast_at_target", 32'(at_target_a), 32'd1);
    countHighs(256, highs);
    checkOutput("fast_highs_per_period", 32'(highs), 32'd255);
    checkOutput("fast_hold_no_wrap", 32'(duty_a), 32'd255);

    // FAST -> OFF: duty walks down one count per period.
    applyStimulus(2'b00);
    waitCycles(256);
    checkOutput("down_duty_254", 32'(duty_a), 32'd254);
    checkOutput("down_at_target", 32'(at_target_a), 32'd0);
    waitCycles(256);
    checkOutput("down_duty_253", 32'(duty_a), 32'd253);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
